motor_lif_bank_4ch: RTL and testbench
=====================================

MOTOR_LIF_BANK_4CH -- requirements
Module: motor_lif_bank_4ch

Interface
REQ-001 SHALL have parameter N_NEURON, default 64, total network neuron count; motor neurons are IDs N_NEURON-4..N_NEURON-1 (N,S,E,W).
REQ-002 SHALL have parameter NEURON_ID_W, default 6, destination-ID width.
REQ-003 SHALL have parameter WEIGHT_W, default 16, signed synaptic weight width.
REQ-004 SHALL have parameter POT_W, default 24, signed membrane-potential width.
REQ-005 SHALL have parameter TH_W, default 16, unsigned threshold width.
REQ-006 SHALL have parameter LEAK_PERIOD, default 16, clk_en cycles between leak ticks.
REQ-007 SHALL have parameter LEAK_SHIFT, default 4, leak = pot >>> LEAK_SHIFT.
REQ-008 SHALL have parameter REFRAC_CYC, default 8, refractory length in clk_en cycles.
REQ-009 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-010 clk_en  in  1  global clock enable; all state holds while 0.
REQ-011 syn_valid_i  in  1  synapse event valid.
REQ-012 syn_ready_o  out  1  block can accept an event this cycle.
REQ-013 syn_dst_id_i  in  NEURON_ID_W  destination neuron ID.
REQ-014 syn_weight_i  in  WEIGHT_W  signed weight.
REQ-015 threshold_i  in  TH_W  firing threshold, shared by all 4 channels.
REQ-016 fire_o  out  4  one-cycle fire pulses, [0]=N [1]=S [2]=E [3]=W.
REQ-017 pot_o  out  4 x POT_W  current potentials, debug.
REQ-018 drop_cnt_o  out  16  saturating count of discarded accepted events.

Function
REQ-019 Accept SHALL occur iff syn_valid_i && syn_ready_o; syn_ready_o = clk_en && !leak_pending.
REQ-020 Accepted event with dst in N_NEURON-4..N_NEURON-1 SHALL map to channel dst-(N_NEURON-4); any other dst SHALL be dropped and drop_cnt_o incremented, saturating at 0xFFFF.
REQ-021 Accept to a non-refractory channel SHALL update pot = sat(pot + sext(weight)), clamped to [-2^(POT_W-1), 2^(POT_W-1)-1].
REQ-022 If the saturated sum >= zext(threshold_i) (signed compare), the block SHALL instead write pot=0, load refrac=REFRAC_CYC, and assert fire_o[ch] in the next clk cycle; threshold_i=0 fires on any sum >= 0.
REQ-023 Accept to a refractory channel (refrac != 0) SHALL discard the weight, leave pot at 0, and increment drop_cnt_o.
REQ-024 fire_o SHALL be high for exactly one clk cycle per fire event, latency 1 cycle from accept; at most one bit high per cycle.
REQ-025 Each refrac counter SHALL decrement by 1 per clk_en cycle while nonzero; the channel is accepting again in the cycle refrac reads 0.
REQ-026 Leak counter SHALL count clk_en cycles 0..LEAK_PERIOD-1 and wrap; on wrap leak_pending SHALL be set for the next clk_en cycle.
REQ-027 In the leak_pending cycle all 4 channels SHALL update pot = pot - (pot >>> LEAK_SHIFT) and syn_ready_o SHALL be 0; leak_pending then clears.
REQ-028 Leak SHALL never change sign or overshoot zero; -1 leaks to 0 and values with |pot| < 2^LEAK_SHIFT leak toward 0 by the arithmetic-shift result.
REQ-029 With clk_en=0, syn_ready_o SHALL be 0; pot, refrac, leak counter, and drop_cnt_o hold; a pending fire_o pulse still clears after one clk cycle.
REQ-030 A threshold_i change SHALL take effect on the next accept; it SHALL NOT trigger a fire by itself.

Reset
REQ-031 On rst_n=0, asynchronously: pot=0, refrac=0, leak counter=0, leak_pending=0, fire_o=0, drop_cnt_o=0; syn_ready_o=0 while in reset.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight fire pulse; the first cycle after release with clk_en=1 SHALL be ready.

Verification
REQ-033 threshold=100, three accepts to dst 62 (E) with weight 40 -> pot_o[2]=40,80; 3rd accept -> fire_o=4'b0100 next cycle, pot_o[2]=0.
REQ-034 After an E fire, weight 500 to dst 62 within 8 clk_en cycles -> no fire, pot_o[2]=0, drop_cnt_o increments; same event on the 9th cycle -> accepted.
REQ-035 pot_o[0]=0x7FFFF0, weight +0x7FFF, threshold=0xFFFF -> pot_o[0]=0x7FFFFF before the next leak; the next leak sets pot_o[0]=0x780000.
REQ-036 Valid held high continuously -> syn_ready_o low exactly 1 cycle in every 17; pot -32 leaks to -30 (LEAK_SHIFT=4).
REQ-037 dst=5 and dst=63 after reset with weight 10 -> drop_cnt_o=1 after the dst=5 event, pot_o[3]=10 after the dst=63 event.
REQ-038 rst_n pulsed low in the same cycle a fire is latched -> fire_o stays 0, all pot_o=0, drop_cnt_o=0.

Source files
------------

// File: rtl/motor_lif_bank_4ch.sv
// motor_lif_bank_4ch: four leaky integrate-and-fire motor neurons (N,S,E,W) driven by a synapse event stream
module motor_lif_bank_4ch #(
  parameter int N_NEURON    = 64,
  parameter int NEURON_ID_W = 6,
  parameter int WEIGHT_W    = 16,
  parameter int POT_W       = 24,
  parameter int TH_W        = 16,
  parameter int LEAK_PERIOD = 16,
  parameter int LEAK_SHIFT  = 4,
  parameter int REFRAC_CYC  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic                        syn_valid_i,
  output logic                        syn_ready_o,
  input  logic [NEURON_ID_W-1:0]      syn_dst_id_i,
  input  logic [WEIGHT_W-1:0]         syn_weight_i,
  input  logic [TH_W-1:0]             threshold_i,
  output logic [3:0]                  fire_o,
  output logic [3:0][POT_W-1:0]       pot_o,
  output logic [15:0]                 drop_cnt_o
);
  localparam int SW = (POT_W > WEIGHT_W ? POT_W : WEIGHT_W) + 1;
  localparam int CW = (SW > TH_W ? SW : TH_W) + 1;
  localparam int RW = $clog2(REFRAC_CYC + 1);
  localparam int LW = $clog2(LEAK_PERIOD + 1);
  localparam logic signed [SW-1:0] POT_MAX = {{(SW-POT_W+1){1'b0}}, {(POT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] POT_MIN = {{(SW-POT_W+1){1'b1}}, {(POT_W-1){1'b0}}};

  logic signed [POT_W-1:0] pot_q [4];
  logic signed [POT_W-1:0] pot_d [4];
  logic [RW-1:0]           refrac_q [4];
  logic [RW-1:0]           refrac_d [4];
  logic [LW-1:0]           leak_cnt_q, leak_cnt_d;
  logic                    leak_pend_q, leak_pend_d;
  logic [3:0]              fire_q, fire_d;
  logic [15:0]             drop_q, drop_d;
  logic [NEURON_ID_W-1:0]  rel;
  logic [1:0]              ch;
  logic                    accept, in_range, refr, fire_now;
  logic signed [SW-1:0]    p_x, w_x, sum;
  logic signed [POT_W-1:0] sat;
  logic signed [CW-1:0]    sat_c, th_c;

  assign syn_ready_o = rst_n && clk_en && !leak_pend_q;
  assign accept      = syn_valid_i && syn_ready_o;
  // out-of-bank IDs wrap to rel >= 4, so one compare decodes the motor range
  assign rel         = syn_dst_id_i - NEURON_ID_W'(N_NEURON - 4);
  assign in_range    = rel < NEURON_ID_W'(4);
  assign ch          = rel[1:0];
  assign refr        = refrac_q[ch] != '0;

  always_comb begin
    p_x = {{(SW-POT_W){pot_q[ch][POT_W-1]}}, pot_q[ch]};
    w_x = {{(SW-WEIGHT_W){syn_weight_i[WEIGHT_W-1]}}, syn_weight_i};
    sum = p_x + w_x;
    sat = sum > POT_MAX ? POT_MAX[POT_W-1:0] : sum < POT_MIN ? POT_MIN[POT_W-1:0] : sum[POT_W-1:0];
    sat_c = {{(CW-POT_W){sat[POT_W-1]}}, sat};
    th_c = {{(CW-TH_W){1'b0}}, threshold_i};
    fire_now = accept && in_range && !refr && sat_c >= th_c;
    fire_d = fire_now ? 4'b0001 << ch : 4'b0000;
    drop_d = drop_q + 16'(accept && (!in_range || refr) && drop_q != 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      refrac_d[i] = clk_en ? refrac_q[i] - RW'(refrac_q[i] != '0) : refrac_q[i];
      pot_d[i] = clk_en && leak_pend_q ? pot_q[i] - (pot_q[i] >>> LEAK_SHIFT) : pot_q[i];
    end
    if (accept && in_range && !refr) begin
      pot_d[ch] = fire_now ? '0 : sat;
      refrac_d[ch] = fire_now ? RW'(REFRAC_CYC) : refrac_d[ch];
    end
    leak_pend_d = clk_en ? !leak_pend_q && leak_cnt_q == LW'(LEAK_PERIOD - 1) : leak_pend_q;
    leak_cnt_d = !clk_en || leak_pend_q ? leak_cnt_q :
                 leak_cnt_q == LW'(LEAK_PERIOD - 1) ? '0 : leak_cnt_q + LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pot_q       <= '{default: '0};
      refrac_q    <= '{default: '0};
      leak_cnt_q  <= '0;
      leak_pend_q <= 1'b0;
      fire_q      <= '0;
      drop_q      <= '0;
    end else begin
      pot_q       <= pot_d;
      refrac_q    <= refrac_d;
      leak_cnt_q  <= leak_cnt_d;
      leak_pend_q <= leak_pend_d;
      fire_q      <= fire_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) pot_o[i] = pot_q[i];
  end
  assign fire_o     = fire_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_motor_lif_bank_4ch.sv
// tb_motor_lif_bank_4ch: scoreboard bench for the motor LIF bank, built with a 16-bit potential so the
// threshold range (0xFFFF) sits above the potential range and saturation is reachable without firing.
module tb_motor_lif_bank_4ch;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clk_en = 1'b0;
  logic              syn_valid_i = 1'b0;
  logic              syn_ready_o;
  logic [5:0]        syn_dst_id_i = '0;
  logic [15:0]       syn_weight_i = '0;
  logic [15:0]       threshold_i = '0;
  logic [3:0]        fire_o;
  logic [3:0][15:0]  pot_o;
  logic [15:0]       drop_cnt_o;

  motor_lif_bank_4ch #(.POT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .syn_valid_i(syn_valid_i), .syn_ready_o(syn_ready_o),
    .syn_dst_id_i(syn_dst_id_i), .syn_weight_i(syn_weight_i),
    .threshold_i(threshold_i), .fire_o(fire_o), .pot_o(pot_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       fire;
    logic [3:0][15:0] pot;
    logic [15:0]      drop;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_pot[4];
  int   m_ref[4];
  int   m_lc, m_drop, th;
  bit   m_lp;
  bit   rdy_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_pot[c] = 0;
      m_ref[c] = 0;
    end
    m_lc = 0;
    m_lp = 0;
    m_drop = 0;
    sb.delete();
  endtask

  // one clk cycle from negedge to negedge; the model predicts the post-edge outputs
  task automatic cyc(input bit en, input bit v, input int dst, input int w);
    exp_t e;
    int   c, s, f;
    bit   rdy;
    clk_en = en;
    syn_valid_i = v;
    syn_dst_id_i = 6'(dst);
    syn_weight_i = 16'(w);
    threshold_i = 16'(th);
    rdy = en && !m_lp;
    #1 rdy_seen = syn_ready_o;
    check("ready", syn_ready_o, rdy);
    f = -1;
    if (rdy && v) begin
      if (dst < 60) begin
        if (m_drop < 65535) m_drop++;
      end else if (m_ref[dst-60] != 0) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        c = dst - 60;
        s = m_pot[c] + w;
        s = s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
        if (s >= th) begin
          m_pot[c] = 0;
          f = c;
        end else m_pot[c] = s;
      end
    end
    if (en) begin
      if (m_lp) begin
        for (int k = 0; k < 4; k++) m_pot[k] = m_pot[k] - (m_pot[k] >>> 4);
        m_lp = 0;
      end else if (m_lc == 15) begin
        m_lc = 0;
        m_lp = 1;
      end else m_lc++;
      for (int k = 0; k < 4; k++) if (m_ref[k] != 0) m_ref[k]--;
      if (f >= 0) m_ref[f] = 8;
    end
    e.fire = (f >= 0) ? 4'(1 << f) : 4'b0000;
    for (int k = 0; k < 4; k++) e.pot[k] = 16'(m_pot[k]);
    e.drop = 16'(m_drop);
    sb.push_back(e);
    @(posedge clk);
    #1 e = sb.pop_front();
    check("fire", fire_o, e.fire);
    for (int k = 0; k < 4; k++) check($sformatf("pot%0d", k), pot_o[k], e.pot[k]);
    check("drop", drop_cnt_o, e.drop);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_en = 1'b1;
    syn_valid_i = 1'b1;
    syn_dst_id_i = 6'd60;
    #1 check("rst_ready", syn_ready_o, 1'b0);
    model_clear();
    @(posedge clk);
    #1 check("rst_fire", fire_o, 4'b0000);
    check("rst_drop", drop_cnt_o, 16'h0000);
    for (int k = 0; k < 4; k++) check($sformatf("rst_pot%0d", k), pot_o[k], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    syn_valid_i = 1'b0;
  endtask

  initial begin
    int w, lows, last_low;
    @(negedge clk);
    do_reset();

    // integrate to threshold, then refractory window
    th = 100;
    cyc(1, 1, 62, 40);
    check("e_pot_40", pot_o[2], 16'd40);
    cyc(1, 1, 62, 40);
    check("e_pot_80", pot_o[2], 16'd80);
    cyc(1, 1, 62, 40);
    check("e_fire", fire_o, 4'b0100);
    check("e_pot_0", pot_o[2], 16'd0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 62, 500);
    check("refr_drop", drop_cnt_o, 16'd8);
    check("refr_pot", pot_o[2], 16'd0);
    cyc(1, 1, 62, 500);
    check("refr_end_fire", fire_o, 4'b0100);

    // out-of-bank drop and W channel mapping
    do_reset();
    th = 100;
    cyc(1, 1, 5, 10);
    check("dst5_drop", drop_cnt_o, 16'd1);
    cyc(1, 1, 63, 10);
    check("dst63_pot", pot_o[3], 16'd10);

    // ready duty cycle under continuous valid, negative leak
    do_reset();
    lows = 0;
    last_low = 0;
    for (int i = 1; i <= 51; i++) begin
      cyc(1, 1, i == 1 ? 63 : 5, i == 1 ? -32 : 0);
      if (!rdy_seen) begin
        lows++;
        if (last_low > 0) check("leak_gap", i - last_low, 17);
        last_low = i;
      end
      if (i == 17) check("leak_neg32", pot_o[3], 16'hFFE2);
    end
    check("leak_lows", lows, 3);

    // saturation both ways, then leak of extremes and of -1
    do_reset();
    th = 16'hFFFF;
    cyc(1, 1, 60, 16'h7FF0);
    check("sat_pre", pot_o[0], 16'h7FF0);
    cyc(1, 1, 60, 16'h7FFF);
    check("sat_pos", pot_o[0], 16'h7FFF);
    cyc(1, 1, 61, -32768);
    cyc(1, 1, 61, -32768);
    check("sat_neg", pot_o[1], 16'h8000);
    cyc(1, 1, 62, -1);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
    check("leak_max", pot_o[0], 16'h7800);
    check("leak_min", pot_o[1], 16'h8800);
    check("leak_m1", pot_o[2], 16'h0000);

    // threshold zero fires on any non-negative sum
    do_reset();
    th = 0;
    cyc(1, 1, 63, -5);
    check("th0_neg", pot_o[3], 16'hFFFB);
    cyc(1, 1, 61, 0);
    check("th0_fire", fire_o, 4'b0010);

    // clk_en low holds state, clears pulse
    do_reset();
    th = 50;
    cyc(1, 1, 60, 60);
    check("en_fire", fire_o, 4'b0001);
    cyc(0, 1, 60, 60);
    check("en_clear", fire_o, 4'b0000);
    for (int i = 0; i < 3; i++) cyc(0, 1, 63, 10);
    check("en_hold_pot", pot_o[3], 16'd0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 60, 60);
    check("en_refr_drop", drop_cnt_o, 16'd8);
    cyc(1, 1, 60, 60);
    check("en_refr_fire", fire_o, 4'b0001);

    // threshold change alone never fires
    cyc(1, 1, 63, 40);
    th = 10;
    cyc(1, 0, 63, 0);
    check("th_chg_nofire", fire_o, 4'b0000);
    cyc(1, 1, 63, 1);
    check("th_chg_fire", fire_o, 4'b1000);

    // random traffic against the model
    do_reset();
    th = 150;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 31) == 0) th = $urandom_range(0, 300);
      w = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                        : int'($urandom_range(0, 300)) - 120;
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(56, 63), w);
    end

    // reset landing on a latched fire
    do_reset();
    th = 10;
    cyc(1, 1, 5, 0);
    cyc(1, 1, 63, 5);
    clk_en = 1'b1;
    syn_valid_i = 1'b1;
    syn_dst_id_i = 6'd60;
    syn_weight_i = 16'd20;
    threshold_i = 16'd10;
    @(posedge clk);
    #1 check("r_latch", fire_o, 4'b0001);
    rst_n = 1'b0;
    #1 check("r_fire", fire_o, 4'b0000);
    check("r_drop", drop_cnt_o, 16'd0);
    check("r_pot3", pot_o[3], 16'd0);
    check("r_ready", syn_ready_o, 1'b0);
    @(negedge clk);
    do_reset();
    cyc(1, 1, 62, 7);
    check("post_rst_pot", pot_o[2], 16'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
